cheby_t_writer: RTL

Computes the Chebyshev table T(0)..T(N_TERMS-1) at a given Q1.15 abscissa x using the recurrence T(k+1) = 2·x·T(k) − T(k−1). Writes each term, in address order, to the write port of a coefficient RAM. It is the producer side of the T-table interface. The systolic filter's read side then fetches T(k) by 3-bit address exactly as it does from the fixed per-x ROMs, so the filter can be re-targeted to a new x at run time without regenerating ROMs.

---
 rtl/cheby_t_writer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cheby_t_writer.sv
// Fills a T-table RAM with Chebyshev terms T(0)..T(N_TERMS-1) at a Q1.15 abscissa x.
// One term per write strobe; 2 cycles per term after the two seeds; start accepted only when not running.
module cheby_t_writer #(
  parameter int N_TERMS = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              c_clk,
  input  logic              c_rst,
  input  logic [15:0]       i_x,
  input  logic              c_start,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_wr_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED0,
    S_SEED1,
    S_MUL,
    S_UPD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(N_TERMS - 1);
  localparam logic [15:0]       ONE_Q15 = 16'h7FFF;

  state_t             r_state;
  state_t             w_next;
  logic signed [15:0] r_x;
  logic signed [15:0] r_t_prev;
  logic signed [15:0] r_t_cur;
  logic signed [31:0] r_p;
  logic [ADDR_W-1:0]  r_k;
  logic signed [17:0] w_q;
  logic signed [17:0] w_s;
  logic               w_ovf_hi;
  logic               w_ovf_lo;
  logic [15:0]        w_res;
  logic               w_accept;

  // DONE behaves as an idle cycle so a new start may overlap the completion pulse.
  assign w_accept = c_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // 2*x*T(k) in Q1.15: Q2.30 product shifted right by 14 with floor rounding.
  assign w_q      = 18'(r_p >>> 14);
  assign w_s      = w_q - {{2{r_t_prev[15]}}, r_t_prev};
  assign w_ovf_hi = !w_s[17] && (w_s[16:15] != 2'b00);
  assign w_ovf_lo =  w_s[17] && (w_s[16:15] != 2'b11);

  always_comb begin
    w_res = w_s[15:0];
    if (w_ovf_hi) begin
      w_res = 16'h7FFF;
    end else if (w_ovf_lo) begin
      w_res = 16'h8000;
    end
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? S_SEED0 : S_IDLE;
      S_SEED0:        w_next = S_SEED1;
      S_SEED1:        w_next = (N_TERMS == 2) ? S_DONE : S_MUL;
      S_MUL:          w_next = S_UPD;
      S_UPD:          w_next = (r_k == LAST_K) ? S_DONE : S_MUL;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_x       <= '0;
      r_t_prev  <= '0;
      r_t_cur   <= '0;
      r_p       <= '0;
      r_k       <= '0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_wr_en   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_sat     <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      o_busy  <= (r_state != S_IDLE) && (r_state != S_DONE);
      o_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (c_start) begin
            r_x   <= i_x;
            o_sat <= 1'b0;
          end
        end
        S_SEED0: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= '0;
          o_wr_data <= ONE_Q15;
          r_t_prev  <= ONE_Q15;
        end
        S_SEED1: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= ADDR_W'(1);
          o_wr_data <= r_x;
          r_t_cur   <= r_x;
          r_k       <= ADDR_W'(2);
        end
        S_MUL: begin
          r_p <= r_x * r_t_cur;
        end
        S_UPD: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= r_k;
          o_wr_data <= w_res;
          if (w_ovf_hi || w_ovf_lo) begin
            o_sat <= 1'b1;
          end
          r_t_prev  <= r_t_cur;
          r_t_cur   <= w_res;
          r_k       <= r_k + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
